// File: rtl/snake_body_engine.sv
// Snake movement, segment storage, collision and occupancy query.
// Define SNAKE_WRAP_EN to make grid edges wrap instead of ending the game.
module snake_body_engine #(
  parameter int GRID_W      = 32,
  parameter int GRID_H      = 24,
  parameter int XW          = 5,
  parameter int YW          = 5,
  parameter int MAX_LEN     = 16,
  parameter int LW          = 5,
  parameter int TICK_CYCLES = 25_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    direction,
  input  logic          grow,
  input  logic [XW-1:0] cell_x,
  input  logic [YW-1:0] cell_y,
  output logic          cell_body,
  output logic          cell_head,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic          step,
  output logic          game_over
);

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam int CW = $clog2(TICK_CYCLES);

  typedef enum logic {RUN, OVER} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];
  logic [1:0]    heading, hd_nx;
  logic          grow_pending, grow_eff, tick;
  logic          wall, self_hit, collide;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [LW-1:0] lim;
  logic          q_body, q_head;

  assign tick     = (state == RUN) && (cnt == CW'(TICK_CYCLES - 1));
  assign grow_eff = grow_pending | grow;
  // A reversal would fold the head straight into seg1
  assign hd_nx    = ((direction ^ heading) == 2'b10) ? heading : direction;
  assign head_x   = seg_x[0];
  assign head_y   = seg_y[0];

  always_comb begin
    nx   = seg_x[0];
    ny   = seg_y[0];
    wall = 1'b0;
    unique case (hd_nx)
      2'b00:
        if (seg_y[0] == '0) begin
          wall = !WRAP;
          ny   = YW'(GRID_H - 1);
        end else ny = seg_y[0] - 1'b1;
      2'b01:
        if (seg_x[0] == XW'(GRID_W - 1)) begin
          wall = !WRAP;
          nx   = '0;
        end else nx = seg_x[0] + 1'b1;
      2'b10:
        if (seg_y[0] == YW'(GRID_H - 1)) begin
          wall = !WRAP;
          ny   = '0;
        end else ny = seg_y[0] + 1'b1;
      2'b11:
        if (seg_x[0] == '0) begin
          wall = !WRAP;
          nx   = XW'(GRID_W - 1);
        end else nx = seg_x[0] - 1'b1;
    endcase
  end

  // Without growth the tail cell is vacated by this same move
  always_comb begin
    lim      = grow_eff ? length : length - 1'b1;
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      if (LW'(i) < lim && seg_x[i] == nx && seg_y[i] == ny)
        self_hit = 1'b1;
  end

  assign collide = wall | self_hit;

  always_comb begin
    q_body = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      if (LW'(i) < length && seg_x[i] == cell_x && seg_y[i] == cell_y)
        q_body = 1'b1;
    q_head = (seg_x[0] == cell_x) && (seg_y[0] == cell_y);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == RUN && tick && collide) state_nx = OVER;
  end

  always_comb begin
    game_over = (state == OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      heading      <= 2'b00;
      grow_pending <= 1'b0;
      step         <= 1'b0;
      length       <= LW'(3);
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= XW'(GRID_W / 2);
        seg_y[i] <= (i < 3) ? YW'(GRID_H / 2 + i) : '0;
      end
    end else begin
      step <= 1'b0;
      if (state == RUN) begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (grow) grow_pending <= 1'b1;
        if (tick && !collide) begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0]     <= nx;
          seg_y[0]     <= ny;
          heading      <= hd_nx;
          step         <= 1'b1;
          grow_pending <= 1'b0;
          if (grow_eff && length < LW'(MAX_LEN))
            length <= length + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cell_body <= 1'b0;
      cell_head <= 1'b0;
    end else begin
      cell_body <= q_body;
      cell_head <= q_head;
    end
  end

endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Movement and body-storage stage directly downstream of the direction selector. Latches the 2-bit rotating direction once per move tick, advances the snake head one grid cell, shifts the body segment buffer, handles growth, and detects self/wall collisions. Exposes head position, length, a step pulse, and a registered cell-occupancy query port for the display renderer.

## Interface
- `GRID_W`, 32: grid width in cells (power of two not required, ≥ 8)
- `GRID_H`, 24: grid height in cells (≥ 8)
- `XW`, 5: x coordinate width, ≥ clog2(GRID_W)
- `YW`, 5: y coordinate width, ≥ clog2(GRID_H)
- `MAX_LEN`, 16: segment buffer depth (≥ 4)
- `LW`, 5: length width, holds MAX_LEN
- `TICK_CYCLES`, 25_000_000: clk cycles per move step (≥ 2)

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock
- `rst` in 1: synchronous active-high reset
- `direction` in 2: 00 up, 01 right, 10 down, 11 left (y grows downward)
- `grow` in 1: one-cycle pulse, food eaten
- `cell_x` in XW / `cell_y` in YW: occupancy query coordinate
- `cell_body` out 1: query cell holds any live segment (registered)
- `cell_head` out 1: query cell is the head (registered)
- `head_x` out XW / `head_y` out YW: current head cell
- `length` out LW: live segment count
- `step` out 1: one-cycle pulse on each committed move
- `game_over` out 1: sticky collision flag

## Operation
- States: RUN, OVER. Reset enters RUN.
- Reset values: head (GRID_W/2, GRID_H/2); seg1 at (GRID_W/2, GRID_H/2+1), seg2 at (GRID_W/2, GRID_H/2+2); length 3; current heading 00; tick counter 0; grow_pending 0; step 0; game_over 0; cell_body 0; cell_head 0. Segments ≥ length are don't-care but never reported.
- Tick counter runs 0..TICK_CYCLES-1 only in RUN; tick asserted when counter = TICK_CYCLES-1.
- `grow` pulse sets grow_pending; cleared on the tick that consumes it. grow in the same cycle as tick counts for that tick.
- On tick: candidate heading = `direction`, unless it is the exact opposite of current heading (XOR = 2'b10), then current heading kept. New head = head ± 1 on the heading axis.
- Self collision: new head equals seg[i] for i < length-1 (no growth; tail vacates) or i < length (growth).
- Wall/self collision -> game_over=1, state OVER, segments, length, heading unchanged, no step pulse.
- Otherwise: seg[i] <= seg[i-1] for i ≥ 1, seg[0] <= new head, heading updated, step=1 for one cycle; length += 1 if grow_pending and length < MAX_LEN (at MAX_LEN growth is discarded, pending still cleared).
- OVER: all state frozen, grow ignored, query port still live; exit only via rst.
- Query: cell_body/cell_head compare against seg[0..length-1] at the clk edge after cell_x/cell_y are presented.

## Timing
- Query latency 1 cycle, every cycle, independent of state.
- head_x/head_y/length/step/game_over all update on the tick edge; visible the cycle after the tick.
- First tick occurs TICK_CYCLES cycles after rst deasserts.
- Query in the tick cycle reflects pre-move positions.
- rst asserted mid-run or in OVER: all outputs at reset values on the next edge; rst overrides tick and grow.

## Configuration
- `SNAKE_WRAP_EN` defined: edges wrap (x=GRID_W-1 right -> 0, x=0 left -> GRID_W-1; likewise y); only self collision ends the game.
- Undefined: a move leaving 0..GRID_W-1 / 0..GRID_H-1 is a wall collision -> OVER, positions frozen.

## Test plan
- Reset, TICK_CYCLES=4, direction=00, no grow -> step every 4 cycles; head (16,12)->(16,11)->(16,10); length stays 3.
- direction=10 (opposite of 00) held -> heading stays up; head continues (16,11); no collision.
- grow pulse then tick -> length 4 after that tick; 13 further grow+tick pairs -> length saturates at 16.
- Without SNAKE_WRAP_EN, direction=11 from x=16 -> after 16 moves at x=0, 17th tick -> game_over=1, head stays (0,y), no step; with macro -> head x=31.
- Length 5, turn right/down/left sequence into own body -> game_over on the colliding tick; rst -> head (16,12), length 3, game_over 0.
- Query cell_x=16, cell_y=13 after reset -> cell_body=1, cell_head=0 one cycle later; (16,12) -> both 1; (0,0) -> both 0.
